ahb_dmem_arbiter: RTL and testbench

AHB_DMEM_ARBITER -- requirements
Module: ahb_dmem_arbiter

---
 rtl/ahb_dmem_arbiter_if.sv | 60 ++++++
 rtl/ahb_dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_ahb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dmem_arbiter_if.sv
// Bus bundle for the two-master AHB data-memory arbiter: per-master request/response
// signals, the shared slave-side bus, and the data-phase owner status.
interface ahb_dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [1:0]    m0_htrans;
  logic [AW-1:0] m0_haddr;
  logic          m0_hwrite;
  logic [2:0]    m0_hsize;
  logic [3:0]    m0_hprot;
  logic [DW-1:0] m0_hwdata;
  logic          m0_hready;
  logic [DW-1:0] m0_hrdata;
  logic          m0_hresp;

  logic [1:0]    m1_htrans;
  logic [AW-1:0] m1_haddr;
  logic          m1_hwrite;
  logic [2:0]    m1_hsize;
  logic [3:0]    m1_hprot;
  logic [DW-1:0] m1_hwdata;
  logic          m1_hready;
  logic [DW-1:0] m1_hrdata;
  logic          m1_hresp;

  logic [1:0]    s_htrans;
  logic [AW-1:0] s_haddr;
  logic          s_hwrite;
  logic [2:0]    s_hsize;
  logic [3:0]    s_hprot;
  logic [DW-1:0] s_hwdata;
  logic          s_hready;
  logic [DW-1:0] s_hrdata;
  logic          s_hresp;

  logic          owner_o;

  // Arbiter view: the slave of both masters and driver of the shared slave bus.
  modport slave (
    input  m0_htrans, m0_haddr, m0_hwrite, m0_hsize, m0_hprot, m0_hwdata,
    output m0_hready, m0_hrdata, m0_hresp,
    input  m1_htrans, m1_haddr, m1_hwrite, m1_hsize, m1_hprot, m1_hwdata,
    output m1_hready, m1_hrdata, m1_hresp,
    output s_htrans, s_haddr, s_hwrite, s_hsize, s_hprot, s_hwdata,
    input  s_hready, s_hrdata, s_hresp,
    output owner_o
  );

  // Environment view: both masters plus the muxed slave response.
  modport master (
    output m0_htrans, m0_haddr, m0_hwrite, m0_hsize, m0_hprot, m0_hwdata,
    input  m0_hready, m0_hrdata, m0_hresp,
    output m1_htrans, m1_haddr, m1_hwrite, m1_hsize, m1_hprot, m1_hwdata,
    input  m1_hready, m1_hrdata, m1_hresp,
    input  s_htrans, s_haddr, s_hwrite, s_hsize, s_hprot, s_hwdata,
    output s_hready, s_hrdata, s_hresp,
    input  owner_o
  );
endinterface

// File: rtl/ahb_dmem_arbiter.sv
// Two-master AHB-lite data-memory arbiter with one-deep per-master pending buffers.
// AHB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise master 0 has fixed priority.
module ahb_dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic               clk,
  input logic               rst,
  ahb_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [3:0]    prot;
  } ctrl_t;

  ctrl_t         live_c [2];
  ctrl_t         pend_q [2];
  ctrl_t         pend_d [2];
  ctrl_t         sel_c;
  logic [1:0]    htrans_hi;
  logic [1:0]    hready_m;
  logic [1:0]    req_live;
  logic [1:0]    want;
  logic [1:0]    grant;
  logic [1:0]    pend_v_q, pend_v_d;
  logic          addr_go;
  logic          gnt_id;
  logic          owner_q, owner_d;
  logic          dvalid_q, dvalid_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          unused_htrans_lsb;
`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic          ptr_q, ptr_d;
`endif

  assign unused_htrans_lsb = bus.m0_htrans[0] ^ bus.m1_htrans[0];

  always_comb begin
    live_c[0] = '{addr: bus.m0_haddr, write: bus.m0_hwrite, size: bus.m0_hsize, prot: bus.m0_hprot};
    live_c[1] = '{addr: bus.m1_haddr, write: bus.m1_hwrite, size: bus.m1_hsize, prot: bus.m1_hprot};
    htrans_hi = {bus.m1_htrans[1], bus.m0_htrans[1]};
  end

  // A master stalls while it has a buffered request or while its own data phase waits.
  always_comb begin
    hready_m = '0;
    req_live = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      hready_m[n] = ~pend_v_q[n] & ((owner_q != 1'(n)) | bus.s_hready | ~dvalid_q);
      req_live[n] = htrans_hi[n] & hready_m[n] & ~rst;
    end
    want = req_live | pend_v_q;
  end

  always_comb begin
    grant = '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    if (want == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else               grant = want;
`else
    grant = {want[1] & ~want[0], want[0]};
`endif
    addr_go = bus.s_hready & (|grant) & ~rst;
    gnt_id  = grant[1];
    sel_c   = pend_v_q[gnt_id] ? pend_q[gnt_id] : live_c[gnt_id];
  end

  // An accepted live request that is not granted this cycle is parked in the buffer.
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      pend_v_d[n] = pend_v_q[n];
      pend_d[n]   = pend_q[n];
      if (addr_go && (gnt_id == 1'(n))) begin
        pend_v_d[n] = 1'b0;
      end else if (req_live[n]) begin
        pend_v_d[n] = 1'b1;
        pend_d[n]   = live_c[n];
      end
    end
    owner_d  = addr_go ? gnt_id : owner_q;
    dvalid_d = bus.s_hready ? addr_go : dvalid_q;
    haddr_d  = addr_go ? sel_c.addr : haddr_q;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    ptr_d    = addr_go ? ~gnt_id : ptr_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q <= '0;
      for (int unsigned n = 0; n < 2; n++) pend_q[n] <= '0;
      owner_q  <= 1'b0;
      dvalid_q <= 1'b0;
      haddr_q  <= '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      pend_v_q <= pend_v_d;
      for (int unsigned n = 0; n < 2; n++) pend_q[n] <= pend_d[n];
      owner_q  <= owner_d;
      dvalid_q <= dvalid_d;
      haddr_q  <= haddr_d;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    bus.s_htrans  = addr_go ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.s_haddr   = addr_go ? sel_c.addr : haddr_q;
    bus.s_hwrite  = addr_go & sel_c.write;
    bus.s_hsize   = addr_go ? sel_c.size : '0;
    bus.s_hprot   = addr_go ? sel_c.prot : '0;
    bus.s_hwdata  = owner_q ? bus.m1_hwdata : bus.m0_hwdata;
    bus.m0_hrdata = (~rst & ~owner_q) ? bus.s_hrdata : '0;
    bus.m1_hrdata = (~rst &  owner_q) ? bus.s_hrdata : '0;
    bus.m0_hresp  = ~rst & ~owner_q & bus.s_hresp;
    bus.m1_hresp  = ~rst &  owner_q & bus.s_hresp;
    bus.m0_hready = hready_m[0];
    bus.m1_hready = hready_m[1];
    bus.owner_o   = owner_q;
  end
endmodule

// File: tb/tb_ahb_dmem_arbiter.sv
// Directed self-checking bench for ahb_dmem_arbiter; expectations adapt to AHB_ARB_ROUND_ROBIN_EN.
module tb_ahb_dmem_arbiter;
`ifdef AHB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ahb_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  ahb_dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w);
    bus.m0_htrans = t; bus.m0_haddr = a; bus.m0_hwrite = w;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w);
    bus.m1_htrans = t; bus.m1_haddr = a; bus.m1_hwrite = w;
  endtask

  task automatic slv(input logic rdy, input logic resp);
    bus.s_hready = rdy; bus.s_hresp = resp;
  endtask

  task automatic do_reset();
    next();
    rst = 1'b1;
    drv0(2'b00, 32'h0, 1'b0);
    drv1(2'b00, 32'h0, 1'b0);
    slv(1'b1, 1'b0);
    next();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_a;
    logic        exp_r;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.m0_hsize = 3'd2; bus.m0_hprot = 4'h3; bus.m0_hwdata = 32'h0;
    bus.m1_hsize = 3'd2; bus.m1_hprot = 4'h3; bus.m1_hwdata = 32'h0;
    bus.s_hrdata = 32'hDEADBEEF;
    drv0(2'b10, 32'h0000_1234, 1'b0);
    drv1(2'b00, 32'h0, 1'b0);
    slv(1'b1, 1'b1);

    // Reset values with a live request and an asserted slave response present
    @(negedge clk);
    chk("rst_htrans", bus.s_htrans, 2'b00);
    chk("rst_haddr", bus.s_haddr, 32'h0);
    chk("rst_m0_hready", bus.m0_hready, 1'b1);
    chk("rst_m1_hready", bus.m1_hready, 1'b1);
    chk("rst_owner", bus.owner_o, 1'b0);
    chk("rst_m0_hresp", bus.m0_hresp, 1'b0);
    chk("rst_m0_hrdata", bus.m0_hrdata, 32'h0);

    next();
    rst = 1'b0;
    drv0(2'b00, 32'h0, 1'b0);
    slv(1'b1, 1'b0);
    @(negedge clk);
    chk("idle_htrans", bus.s_htrans, 2'b00);

    // Simultaneous requests: m0 first, m1 one cycle later from its buffer
    next();
    drv0(2'b10, 32'hFFFF_0000, 1'b0);
    drv1(2'b10, 32'hFF01_0000, 1'b1);
    @(negedge clk);
    chk("tie_htrans", bus.s_htrans, 2'b10);
    chk("tie_haddr", bus.s_haddr, 32'hFFFF_0000);
    chk("tie_m1_hready0", bus.m1_hready, 1'b1);
    next();
    drv0(2'b00, 32'h0, 1'b0);
    drv1(2'b00, 32'h0, 1'b0);
    bus.m1_hwdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("tie_m1_stall", bus.m1_hready, 1'b0);
    chk("tie_haddr_m1", bus.s_haddr, 32'hFF01_0000);
    chk("tie_hwrite_m1", bus.s_hwrite, 1'b1);
    chk("tie_owner_m0", bus.owner_o, 1'b0);
    next();
    @(negedge clk);
    chk("tie_m1_ready", bus.m1_hready, 1'b1);
    chk("tie_owner_m1", bus.owner_o, 1'b1);
    chk("tie_hwdata", bus.s_hwdata, 32'h5555_AAAA);
    chk("tie_idle", bus.s_htrans, 2'b00);

    // Single m0 read passes through in the same cycle
    next();
    drv0(2'b10, 32'hFFFF_0004, 1'b0);
    @(negedge clk);
    chk("solo_htrans", bus.s_htrans, 2'b10);
    chk("solo_haddr", bus.s_haddr, 32'hFFFF_0004);
    chk("solo_m0_hready", bus.m0_hready, 1'b1);
    next();
    drv0(2'b00, 32'h0, 1'b0);
    bus.s_hrdata = 32'h1111_2222;
    @(negedge clk);
    chk("solo_owner", bus.owner_o, 1'b0);
    chk("solo_haddr_hold", bus.s_haddr, 32'hFFFF_0004);
    chk("solo_m0_hrdata", bus.m0_hrdata, 32'h1111_2222);
    chk("solo_m1_hrdata", bus.m1_hrdata, 32'h0);

    // Both masters request continuously
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv0(2'b10, 32'h0000_1000, 1'b0);
      drv1(2'b10, 32'h0000_2000, 1'b0);
      exp_a = (RR && (i % 2 == 1)) ? 32'h0000_2000 : 32'h0000_1000;
      exp_r = (i == 0) ? 1'b1 : (RR ? (i % 2 == 0) : 1'b0);
      @(negedge clk);
      chk($sformatf("cont_haddr_%0d", i), bus.s_haddr, exp_a);
      chk($sformatf("cont_m1_hready_%0d", i), bus.m1_hready, exp_r);
      next();
    end
    drv0(2'b00, 32'h0, 1'b0);
    drv1(2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("cont_after_haddr", bus.s_haddr, RR ? 32'h0000_1000 : 32'h0000_2000);

    // Slave wait states on an m1 write; m0 request buffered meanwhile
    do_reset();
    drv1(2'b10, 32'h0000_3000, 1'b1);
    @(negedge clk);
    chk("ws_haddr", bus.s_haddr, 32'h0000_3000);
    chk("ws_hwrite", bus.s_hwrite, 1'b1);
    next();
    drv1(2'b00, 32'h0, 1'b0);
    bus.m1_hwdata = 32'hA5A5_A5A5;
    drv0(2'b10, 32'h0000_4000, 1'b0);
    slv(1'b0, 1'b0);
    @(negedge clk);
    chk("ws1_m1_hready", bus.m1_hready, 1'b0);
    chk("ws1_hwdata", bus.s_hwdata, 32'hA5A5_A5A5);
    chk("ws1_htrans", bus.s_htrans, 2'b00);
    chk("ws1_m0_hready", bus.m0_hready, 1'b1);
    next();
    drv0(2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("ws2_m1_hready", bus.m1_hready, 1'b0);
    chk("ws2_m0_hready", bus.m0_hready, 1'b0);
    chk("ws2_hwdata", bus.s_hwdata, 32'hA5A5_A5A5);
    next();
    @(negedge clk);
    chk("ws3_m1_hready", bus.m1_hready, 1'b0);
    chk("ws3_hwdata", bus.s_hwdata, 32'hA5A5_A5A5);
    next();
    slv(1'b1, 1'b0);
    @(negedge clk);
    chk("ws4_m1_hready", bus.m1_hready, 1'b1);
    chk("ws4_htrans", bus.s_htrans, 2'b10);
    chk("ws4_haddr", bus.s_haddr, 32'h0000_4000);
    next();
    @(negedge clk);
    chk("ws5_owner", bus.owner_o, 1'b0);
    chk("ws5_m0_hready", bus.m0_hready, 1'b1);
    chk("ws5_htrans", bus.s_htrans, 2'b00);

    // Two-cycle ERROR to m0 with m1 waiting
    do_reset();
    drv0(2'b10, 32'h0000_5000, 1'b0);
    @(negedge clk);
    chk("err_haddr", bus.s_haddr, 32'h0000_5000);
    next();
    drv0(2'b00, 32'h0, 1'b0);
    drv1(2'b10, 32'h0000_6000, 1'b0);
    slv(1'b0, 1'b1);
    @(negedge clk);
    chk("err1_m0_hresp", bus.m0_hresp, 1'b1);
    chk("err1_m1_hresp", bus.m1_hresp, 1'b0);
    chk("err1_m0_hready", bus.m0_hready, 1'b0);
    chk("err1_htrans", bus.s_htrans, 2'b00);
    next();
    drv1(2'b00, 32'h0, 1'b0);
    slv(1'b1, 1'b1);
    @(negedge clk);
    chk("err2_m0_hresp", bus.m0_hresp, 1'b1);
    chk("err2_m1_hresp", bus.m1_hresp, 1'b0);
    chk("err2_m0_hready", bus.m0_hready, 1'b1);
    chk("err2_htrans", bus.s_htrans, 2'b10);
    chk("err2_haddr", bus.s_haddr, 32'h0000_6000);
    next();
    slv(1'b1, 1'b0);
    @(negedge clk);
    chk("err3_owner", bus.owner_o, 1'b1);
    chk("err3_m1_hready", bus.m1_hready, 1'b1);

    // Reset mid-transfer with m1 pending and m0 in a stalled data phase
    next();
    drv0(2'b10, 32'h0000_7000, 1'b0);
    @(negedge clk);
    chk("mr_haddr", bus.s_haddr, 32'h0000_7000);
    next();
    drv0(2'b00, 32'h0, 1'b0);
    drv1(2'b10, 32'h0000_8000, 1'b0);
    slv(1'b0, 1'b0);
    next();
    drv1(2'b00, 32'h0, 1'b0);
    bus.s_hrdata = 32'hCAFE_F00D;
    slv(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_htrans", bus.s_htrans, 2'b00);
    chk("mr_haddr0", bus.s_haddr, 32'h0);
    chk("mr_m0_hready", bus.m0_hready, 1'b1);
    chk("mr_m1_hready", bus.m1_hready, 1'b1);
    chk("mr_owner", bus.owner_o, 1'b0);
    chk("mr_m0_hresp", bus.m0_hresp, 1'b0);
    chk("mr_m0_hrdata", bus.m0_hrdata, 32'h0);
    next();
    rst = 1'b0;
    slv(1'b1, 1'b0);
    @(negedge clk);
    chk("mr_post_htrans", bus.s_htrans, 2'b00);
    chk("mr_post_haddr", bus.s_haddr, 32'h0);
    next();
    @(negedge clk);
    chk("mr_post2_htrans", bus.s_htrans, 2'b00);
    chk("mr_post2_m1_hready", bus.m1_hready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
